// File: rtl/minmax_pkg.sv
// Shared types and defaults for the min/max frame tracker.
//   state_e   : frame FSM states (IDLE, FIRST, RUN, DONE)
//   DEF_N     : default sample width in bits
//   DEF_LEN   : default samples per frame
package minmax_pkg;

  localparam int unsigned DEF_N   = 8;
  localparam int unsigned DEF_LEN = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_e;

endpackage : minmax_pkg

// File: rtl/minmax_cmp.sv
// Combinational magnitude comparison of one sample against the running
// maximum and minimum.
//   sample_i  : incoming sample
//   cur_max_i : running maximum register
//   cur_min_i : running minimum register
//   gt_o      : sample strictly greater than cur_max_i (combinational)
//   lt_o      : sample strictly less than cur_min_i (combinational)
// Build option: define MINMAX_SIGNED_EN for two's-complement comparison;
// otherwise the comparison is unsigned.
module minmax_cmp #(
  parameter int unsigned N = 8
) (
  input  logic [N-1:0] sample_i,
  input  logic [N-1:0] cur_max_i,
  input  logic [N-1:0] cur_min_i,
  output logic         gt_o,
  output logic         lt_o
);

  // Strict comparisons: equal values never report, so ties keep the earliest index.
  always_comb begin
`ifdef MINMAX_SIGNED_EN
    gt_o = $signed(sample_i) > $signed(cur_max_i);
    lt_o = $signed(sample_i) < $signed(cur_min_i);
`else
    gt_o = sample_i > cur_max_i;
    lt_o = sample_i < cur_min_i;
`endif
  end

endmodule : minmax_cmp

// File: rtl/minmax_tracker.sv
// Streaming frame statistics: accepts LEN samples over valid/ready and
// reports the frame maximum/minimum and the index of their first occurrence.
//   clk, rst_n          : clock, asynchronous active-low reset
//   start               : begin a frame (registered, acted on only in IDLE)
//   in_valid/in_ready   : sample handshake, in_data is the sample
//   out_valid/out_ready : result handshake, results held until taken
//   max_out/min_out     : result registers (visible at all times)
//   max_idx/min_idx     : first-occurrence indices of max/min
//   busy                : high whenever the FSM is not IDLE
// Build option: MINMAX_SIGNED_EN selects signed comparison (see minmax_cmp).
module minmax_tracker
  import minmax_pkg::*;
#(
  parameter  int unsigned N   = DEF_N,
  parameter  int unsigned LEN = DEF_LEN,
  localparam int unsigned IW  = $clog2(LEN)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [N-1:0]  in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  max_out,
  output logic [N-1:0]  min_out,
  output logic [IW-1:0] max_idx,
  output logic [IW-1:0] min_idx,
  output logic          busy
);

  localparam logic [IW-1:0] LAST_IDX = IW'(LEN - 1);

  state_e        state_q, state_d;
  logic          start_q;
  logic [IW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  max_q, max_d;
  logic [N-1:0]  min_q, min_d;
  logic [IW-1:0] max_idx_q, max_idx_d;
  logic [IW-1:0] min_idx_q, min_idx_d;
  logic          in_ready_q, out_valid_q, busy_q;

  logic accept;
  logic gt, lt;

  assign accept = in_valid & in_ready_q;

  minmax_cmp #(.N(N)) u_cmp (
    .sample_i  (in_data),
    .cur_max_i (max_q),
    .cur_min_i (min_q),
    .gt_o      (gt),
    .lt_o      (lt)
  );

  // Start is only captured while IDLE, so a pulse during DONE (including the
  // handshake cycle) is dropped and must be reasserted in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      start_q <= 1'b0;
    end else begin
      start_q <= start & (state_q == IDLE);
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    max_d     = max_q;
    min_d     = min_q;
    max_idx_d = max_idx_q;
    min_idx_d = min_idx_q;
    case (state_q)
      IDLE: begin
        if (start_q) begin
          state_d = FIRST;
        end
      end
      FIRST: begin
        if (accept) begin
          max_d     = in_data;
          min_d     = in_data;
          max_idx_d = '0;
          min_idx_d = '0;
          cnt_d     = IW'(1);
          state_d   = RUN;
        end
      end
      RUN: begin
        if (accept) begin
          if (gt) begin
            max_d     = in_data;
            max_idx_d = cnt_q;
          end
          if (lt) begin
            min_d     = in_data;
            min_idx_d = cnt_q;
          end
          if (cnt_q == LAST_IDX) begin
            cnt_d   = '0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + IW'(1);
          end
        end
      end
      DONE: begin
        if (out_valid_q && out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, datapath and handshake registers; handshake flags follow state_d
  // so they always match the state they belong to.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      max_q       <= '0;
      min_q       <= '0;
      max_idx_q   <= '0;
      min_idx_q   <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      max_q       <= max_d;
      min_q       <= min_d;
      max_idx_q   <= max_idx_d;
      min_idx_q   <= min_idx_d;
      in_ready_q  <= (state_d == FIRST) || (state_d == RUN);
      out_valid_q <= (state_d == DONE);
      busy_q      <= (state_d != IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign max_out   = max_q;
  assign min_out   = min_q;
  assign max_idx   = max_idx_q;
  assign min_idx   = min_idx_q;

endmodule : minmax_tracker

// File: tb/tb_minmax_tracker.sv
// Directed bench for minmax_tracker with N=8, LEN=4.
module tb_minmax_tracker;

  localparam int unsigned N   = 8;
  localparam int unsigned LEN = 4;
  localparam int unsigned IW  = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_data;
  logic          out_valid;
  logic          out_ready;
  logic [N-1:0]  max_out;
  logic [N-1:0]  min_out;
  logic [IW-1:0] max_idx;
  logic [IW-1:0] min_idx;
  logic          busy;

  int passed = 0;
  int total  = 0;
  int lat;
  logic [N-1:0] smp [LEN];

  always #5 clk = ~clk;

  minmax_tracker #(.N(N), .LEN(LEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .max_out   (max_out),
    .min_out   (min_out),
    .max_idx   (max_idx),
    .min_idx   (min_idx),
    .busy      (busy)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // Pulse start, then feed smp[0..n_acc-1]; with gaps, in_valid follows 1,0,0.
  // When the whole frame is fed, wait (bounded) for out_valid. lat counts
  // cycles from the start cycle to out_valid.
  task automatic run_frame(input int n_acc, input bit gaps, output int lat_o);
    int i;
    int k;
    start = 1'b1;
    tick();
    lat_o = 1;
    start = 1'b0;
    i = 0;
    k = 0;
    while (i < n_acc && lat_o < 100) begin
      in_valid = gaps ? (k % 3 == 0) : 1'b1;
      in_data  = smp[i];
      if (in_valid && in_ready) i++;
      tick();
      lat_o++;
      k++;
    end
    in_valid = 1'b0;
    if (n_acc == LEN) begin
      while (!out_valid && lat_o < 100) begin
        tick();
        lat_o++;
      end
      chk("frame_timeout", 32'(out_valid), 32'd1);
    end
  endtask

  task automatic take_result(input logic also_start);
    out_ready = 1'b1;
    start     = also_start;
    tick();
    out_ready = 1'b0;
    start     = 1'b0;
    chk("take_out_valid", 32'(out_valid), 32'd0);
    chk("take_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_max", 32'(max_out), 32'd0);
    chk("rst_min", 32'(min_out), 32'd0);
    chk("rst_max_idx", 32'(max_idx), 32'd0);
    chk("rst_min_idx", 32'(min_idx), 32'd0);
    rst_n = 1'b1;
    tick();

    // Basic frame
    smp = '{8'd5, 8'd200, 8'd3, 8'd200};
    run_frame(LEN, 1'b0, lat);
    chk("basic_latency", 32'(lat), 32'd6);
    chk("basic_max", 32'(max_out), 32'd200);
    chk("basic_max_idx", 32'(max_idx), 32'd1);
    chk("basic_min", 32'(min_out), 32'd3);
    chk("basic_min_idx", 32'(min_idx), 32'd2);
    chk("basic_busy", 32'(busy), 32'd1);
    chk("basic_in_ready", 32'(in_ready), 32'd0);
    take_result(1'b0);

    // Ties / constant data; start during the handshake cycle must be dropped
    smp = '{8'd7, 8'd7, 8'd7, 8'd7};
    run_frame(LEN, 1'b0, lat);
    chk("tie_latency", 32'(lat), 32'd6);
    chk("tie_max", 32'(max_out), 32'd7);
    chk("tie_min", 32'(min_out), 32'd7);
    chk("tie_max_idx", 32'(max_idx), 32'd0);
    chk("tie_min_idx", 32'(min_idx), 32'd0);
    take_result(1'b1);
    tick();
    tick();
    chk("handshake_start_busy", 32'(busy), 32'd0);
    chk("handshake_start_in_ready", 32'(in_ready), 32'd0);

    // Input backpressure
    smp = '{8'd9, 8'd1, 8'd250, 8'd4};
    run_frame(LEN, 1'b1, lat);
    chk("gap_max", 32'(max_out), 32'd250);
    chk("gap_max_idx", 32'(max_idx), 32'd2);
    chk("gap_min", 32'(min_out), 32'd1);
    chk("gap_min_idx", 32'(min_idx), 32'd1);

    // Output backpressure with start pulsed during DONE
    for (int c = 0; c < 5; c++) begin
      start = (c == 2);
      tick();
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_max", 32'(max_out), 32'd250);
      chk("hold_min_idx", 32'(min_idx), 32'd1);
    end
    start = 1'b0;
    take_result(1'b0);
    tick();
    tick();
    chk("ignored_start_busy", 32'(busy), 32'd0);

    // Reset mid-frame
    smp = '{8'd50, 8'd60, 8'd0, 8'd0};
    run_frame(2, 1'b0, lat);
    chk("mid_busy_before_rst", 32'(busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd0);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_max", 32'(max_out), 32'd0);
    chk("midrst_min", 32'(min_out), 32'd0);
    chk("midrst_max_idx", 32'(max_idx), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    smp = '{8'd10, 8'd20, 8'd30, 8'd40};
    run_frame(LEN, 1'b0, lat);
    chk("post_rst_latency", 32'(lat), 32'd6);
    chk("post_rst_max", 32'(max_out), 32'd40);
    chk("post_rst_max_idx", 32'(max_idx), 32'd3);
    chk("post_rst_min", 32'(min_out), 32'd10);
    chk("post_rst_min_idx", 32'(min_idx), 32'd0);
    take_result(1'b0);

    // Signedness
    smp = '{8'h7F, 8'h80, 8'h00, 8'hFF};
    run_frame(LEN, 1'b0, lat);
`ifdef MINMAX_SIGNED_EN
    chk("sgn_max", 32'(max_out), 32'h7F);
    chk("sgn_max_idx", 32'(max_idx), 32'd0);
    chk("sgn_min", 32'(min_out), 32'h80);
    chk("sgn_min_idx", 32'(min_idx), 32'd1);
`else
    chk("uns_max", 32'(max_out), 32'hFF);
    chk("uns_max_idx", 32'(max_idx), 32'd3);
    chk("uns_min", 32'(min_out), 32'h00);
    chk("uns_min_idx", 32'(min_idx), 32'd2);
`endif
    take_result(1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_minmax_tracker
